// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access sequencer for the RV32I pipeline
// Optional stall-cycle performance counter enabled by defining MEM_PERF_CNT_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic [31:0] perf_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state, state_nxt;
    logic [TO_CNT_W-1:0] cnt;
    logic [2:0]          op_funct3;
    logic [1:0]          op_off;
    logic                op_load;

    logic        access, legal, misaligned, start, reject, to_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    function automatic logic [31:0] fmt_load(input logic [2:0] f, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        h  = off[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // A write wins when both enables are set, so legality follows the store rules.
    always_comb begin
        access = mem_read_en | mem_write_en;
        if (mem_write_en)
            legal = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010);
        else
            legal = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010) ||
                    (mem_funct3 == 3'b100) || (mem_funct3 == 3'b101);
        misaligned = ((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
                     ((mem_funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
        start  = (state == IDLE) && access && legal && !misaligned;
        reject = (state == IDLE) && access && (!legal || misaligned);
        to_hit = (cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

        be_nxt    = 4'b1111;
        wdata_nxt = 32'd0;
        if (mem_write_en) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << mem_addr[1:0];
                    wdata_nxt = {4{mem_wdata[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << mem_addr[1:0];
                    wdata_nxt = {2{mem_wdata[15:0]}};
                end
                default: wdata_nxt = mem_wdata;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = start;
                if (start) state_nxt = REQ;
            end
            REQ: begin
                mem_stall = 1'b1;
                if (bus_ack || to_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_funct3  <= 3'd0;
            op_off     <= 2'd0;
            op_load    <= 1'b0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_be     <= 4'd0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write_en;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata_nxt;
                        cnt       <= '0;
                        op_funct3 <= mem_funct3;
                        op_off    <= mem_addr[1:0];
                        op_load   <= !mem_write_en;
                    end else if (reject) begin
                        fault      <= 1'b1;
                        fault_code <= legal ? 2'b01 : 2'b10;
                        load_data  <= 32'd0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b11;
                            load_data  <= 32'd0;
                        end else begin
                            fault_code <= 2'b00;
                            if (op_load) begin
                                load_data  <= fmt_load(op_funct3, op_off, bus_rdata);
                                load_valid <= 1'b1;
                            end
                        end
                    end else if (to_hit) begin
                        bus_req    <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                        load_data  <= 32'd0;
                    end else begin
                        cnt <= cnt + TO_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cycles <= 32'd0;
        else if (mem_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
